// File: rtl/regfile_2r1w.sv
// Parametrised register file: one synchronous write port, two enabled registered read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read port.
module regfile_2r1w #(
    parameter int unsigned          WIDTH     = 8,
    parameter int unsigned          DEPTH     = 8,
    parameter int unsigned          AW        = $clog2(DEPTH),
    parameter int unsigned          ZERO_REG  = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_a_d, rd_b_d;

`ifdef REGFILE_BYPASS_EN
    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction
`endif

    // Entry 0 is only assigned at reset when hardwired, so it stays constant zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : RESET_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (we && (waddr == AW'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                    mem_q[i] <= wdata;
                end
            end
        end
    end

    // Addresses with no matching entry fall through to the zero default.
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) rd_a_d = mem_q[i];
            if (raddr_b == AW'(i)) rd_b_d = mem_q[i];
        end
        if ((ZERO_REG != 0) && (raddr_a == '0)) rd_a_d = '0;
        if ((ZERO_REG != 0) && (raddr_b == '0)) rd_b_d = '0;
`ifdef REGFILE_BYPASS_EN
        if (we && writable(waddr) && (waddr == raddr_a)) rd_a_d = wdata;
        if (we && writable(waddr) && (waddr == raddr_b)) rd_b_d = wdata;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= rd_a_d;
            if (re_b) rdata_b <= rd_b_d;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: three configurations driven in lockstep against an
// array-based reference model; expectations are queued at each edge and checked by a monitor.
module tb_regfile_2r1w;

    localparam int NCFG = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       re_a = 1'b0;
    logic [2:0] raddr_a = '0;
    logic       re_b = 1'b0;
    logic [2:0] raddr_b = '0;
    logic [7:0] rda [NCFG];
    logic [7:0] rdb [NCFG];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         c;
        int         p;
        logic [7:0] v;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] mm  [NCFG][8];
    logic [7:0] rdm [NCFG][2];

    always #5 clk = ~clk;

    regfile_2r1w u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[0]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[0])
    );

    regfile_2r1w #(.ZERO_REG(0), .RESET_VAL(8'h5A)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[1]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[1])
    );

    regfile_2r1w #(.DEPTH(6)) u_dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[2]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[2])
    );

    function automatic int depth_of(input int c);
        return (c == 2) ? 6 : 8;
    endfunction

    function automatic bit zr_of(input int c);
        return c != 1;
    endfunction

    function automatic logic [7:0] rv_of(input int c);
        return (c == 1) ? 8'h5A : 8'h00;
    endfunction

    function automatic bit writable_m(input int c, input int a);
        return (a < depth_of(c)) && !(zr_of(c) && a == 0);
    endfunction

    function automatic logic [7:0] read_m(input int c, input int a);
        return writable_m(c, a) || (!zr_of(c) && a == 0) ? mm[c][a] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int a = 0; a < 8; a++) mm[c][a] = writable_m(c, a) ? rv_of(c) : 8'h00;
            rdm[c][0] = 8'h00;
            rdm[c][1] = 8'h00;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One clock: drive, model the edge, queue every port's expected value.
    task automatic step(input bit w, input int wa, input logic [7:0] wd,
                        input bit ea, input int ra, input bit eb, input int rb);
        we = w; waddr = 3'(wa); wdata = wd;
        re_a = ea; raddr_a = 3'(ra); re_b = eb; raddr_b = 3'(rb);
        @(posedge clk);
        for (int c = 0; c < NCFG; c++) begin
            if (ea) rdm[c][0] = (BYP && w && wa == ra && writable_m(c, wa)) ? wd : read_m(c, ra);
            if (eb) rdm[c][1] = (BYP && w && wa == rb && writable_m(c, wa)) ? wd : read_m(c, rb);
        end
        for (int c = 0; c < NCFG; c++) begin
            if (w && writable_m(c, wa)) mm[c][wa] = wd;
            for (int p = 0; p < 2; p++) sbq.push_back('{c: c, p: p, v: rdm[c][p]});
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("sb cfg%0d port%s", e.c, e.p == 0 ? "A" : "B"),
                  e.p == 0 ? rda[e.c] : rdb[e.c], e.v);
        end
    end

    initial begin
        // Reset asserted mid-cycle must clear outputs without an edge.
        #3 rst = 1'b1;
        model_reset();
        re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd7;
        #1;
        check("rst async a", rda[0], 8'h00);
        check("rst async b", rdb[0], 8'h00);
        @(posedge clk); #1;
        check("rst edge a", rda[0], 8'h00);
        check("rst edge b", rdb[1], 8'h00);
        #6 rst = 1'b0;
        step(0, 0, 8'h00, 1, 3, 1, 7);
        check("post rst a", rda[0], 8'h00);
        step(1, 3, 8'h11, 0, 3, 1, 3);
        step(0, 0, 8'h00, 0, 3, 1, 3);
        check("hold a", rda[0], 8'h00);
        check("read b 3", rdb[0], 8'h11);

        step(1, 2, 8'hA5, 0, 0, 0, 0);
        step(1, 5, 8'h3C, 0, 0, 0, 0);
        step(0, 0, 8'h00, 1, 2, 1, 5);
        check("rd a 2", rda[0], 8'hA5);
        check("rd b 5", rdb[0], 8'h3C);
        step(0, 0, 8'h00, 1, 2, 1, 2);
        check("same a", rda[0], 8'hA5);
        check("same b", rdb[0], 8'hA5);

        step(1, 0, 8'hFF, 0, 0, 0, 0);
        step(0, 0, 8'h00, 1, 0, 0, 0);
        check("zero reg", rda[0], 8'h00);
        check("nonzero reg", rda[1], 8'hFF);

        step(1, 4, 8'h12, 0, 0, 0, 0);
        step(1, 4, 8'h34, 1, 4, 0, 0);
        check("rdw", rda[0], BYP ? 8'h34 : 8'h12);
        step(0, 0, 8'h00, 1, 4, 0, 0);
        check("rdw next", rda[0], 8'h34);

        step(1, 7, 8'h77, 0, 0, 0, 0);
        step(0, 0, 8'h00, 1, 7, 1, 6);
        check("oor 7", rda[2], 8'h00);
        check("oor 6", rdb[2], 8'h00);
        for (int a = 0; a < 6; a++) step(0, 0, 8'h00, 1, a, 1, 5 - a);

        for (int a = 1; a < 8; a++) step(1, a, 8'(a), 0, 0, 0, 0);
        we = 1'b1; waddr = 3'd1; wdata = 8'h99;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("mid rst a", rda[1], 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) step(0, 0, 8'h00, 1, a, 1, a);
        step(0, 0, 8'h00, 1, 1, 0, 0);
        check("no 99", rda[1], 8'h5A);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)));
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
